// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-requester memory arbiter:
//   - state_t         : arbiter FSM states (IDLE, ACCESS, ACK)
//   - req_id_t        : requester identifier, REQ_FETCH / REQ_DATA
//   - MEM_LAT_DEFAULT : default number of cycles a memory strobe is held
//   - CNT_W           : width of the access-cycle counter (covers 1..15)
// Optional feature macro used by the importing files: ARB_RR_EN.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ACK    = 2'd2
   } state_t;

   typedef logic req_id_t;

   localparam req_id_t REQ_FETCH = 1'b0;
   localparam req_id_t REQ_DATA  = 1'b1;

   localparam int MEM_LAT_DEFAULT = 1;
   localparam int CNT_W           = 4;

endpackage : mem_arb_pkg

// File: rtl/arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Combinational winner selection between the fetch and data requesters.
// Default build: fixed priority, data wins a tie.
// With ARB_RR_EN defined: a tie goes to the requester that was not granted
// last (last_grant_i comes from the pointer register in the top level).
// Ports:
//   last_grant_i  in  1  requester granted most recently (ARB_RR_EN only)
//   i_req_i       in  1  fetch request
//   d_req_i       in  1  data request
//   grant_valid_o out 1  at least one request is pending
//   grant_id_o    out 1  winning requester (REQ_FETCH / REQ_DATA)
// -----------------------------------------------------------------------------
module arb_pick
   import mem_arb_pkg::*;
(
`ifdef ARB_RR_EN
   input  req_id_t last_grant_i,
`endif
   input  logic    i_req_i,
   input  logic    d_req_i,
   output logic    grant_valid_o,
   output req_id_t grant_id_o
);

   always_comb begin
      grant_valid_o = i_req_i | d_req_i;
`ifdef ARB_RR_EN
      if (i_req_i && d_req_i) begin
         // Alternate on contention: whoever was served last yields.
         grant_id_o = (last_grant_i == REQ_DATA) ? REQ_FETCH : REQ_DATA;
      end else begin
         grant_id_o = d_req_i ? REQ_DATA : REQ_FETCH;
      end
`else
      grant_id_o = d_req_i ? REQ_DATA : REQ_FETCH;
`endif
   end

endmodule : arb_pick

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates an instruction-fetch port (read-only) and a data port
// (load/store) onto one single-port memory. One transfer at a time:
// IDLE picks a winner and latches its request, ACCESS holds the memory
// strobe for MEM_LAT cycles, ACK pulses the winner's ack for one cycle.
// Misaligned addresses skip ACCESS and return ack+err together.
// Optional macro ARB_RR_EN: round-robin tie break instead of data-first.
// Parameters: AW address width, DW data width, MEM_LAT strobe cycles (1-15).
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   i_req/i_addr -> i_rdata/i_ack/i_err            fetch requester
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_ack/d_err data requester
//   mem_addr/mem_wdata/mem_read/mem_write, mem_rdata  memory side
// All outputs are registered.
// -----------------------------------------------------------------------------
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
   input  logic          clk,
   input  logic          reset_n,
   // fetch requester
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic [DW-1:0] i_rdata,
   output logic          i_ack,
   output logic          i_err,
   // data requester
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_ack,
   output logic          d_err,
   // memory
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_read,
   output logic          mem_write,
   input  logic [DW-1:0] mem_rdata
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   req_id_t          win_q;
   logic             we_q;
   logic [AW-1:0]    mem_addr_q;
   logic [DW-1:0]    mem_wdata_q;
   logic             mem_read_q;
   logic             mem_write_q;
   logic             i_ack_q;
   logic             i_err_q;
   logic             d_ack_q;
   logic             d_err_q;
   logic [DW-1:0]    i_rdata_q;
   logic [DW-1:0]    d_rdata_q;

   logic             grant_valid;
   req_id_t          grant_id;
   logic [AW-1:0]    sel_addr;
   logic             sel_we;
   logic             sel_misaligned;

`ifdef ARB_RR_EN
   req_id_t          last_q;

   arb_pick u_pick (
      .last_grant_i  (last_q),
      .i_req_i       (i_req),
      .d_req_i       (d_req),
      .grant_valid_o (grant_valid),
      .grant_id_o    (grant_id)
   );
`else
   arb_pick u_pick (
      .i_req_i       (i_req),
      .d_req_i       (d_req),
      .grant_valid_o (grant_valid),
      .grant_id_o    (grant_id)
   );
`endif

   // Request fields of the current winner; only sampled in IDLE.
   assign sel_addr       = (grant_id == REQ_DATA) ? d_addr : i_addr;
   assign sel_we         = (grant_id == REQ_DATA) && d_we;
   assign sel_misaligned = |sel_addr[1:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         win_q       <= REQ_FETCH;
         we_q        <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         i_ack_q     <= 1'b0;
         i_err_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         d_err_q     <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
`ifdef ARB_RR_EN
         last_q      <= REQ_FETCH;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (grant_valid) begin
                  win_q <= grant_id;
`ifdef ARB_RR_EN
                  last_q <= grant_id;
`endif
                  if (sel_misaligned) begin
                     // Rejected without touching memory: ack+err next cycle.
                     state_q <= ACK;
                     if (grant_id == REQ_DATA) begin
                        d_ack_q <= 1'b1;
                        d_err_q <= 1'b1;
                     end else begin
                        i_ack_q <= 1'b1;
                        i_err_q <= 1'b1;
                     end
                  end else begin
                     state_q     <= ACCESS;
                     cnt_q       <= '0;
                     we_q        <= sel_we;
                     mem_addr_q  <= sel_addr;
                     mem_wdata_q <= d_wdata;
                     mem_read_q  <= ~sel_we;
                     mem_write_q <= sel_we;
                  end
               end
            end

            ACCESS: begin
               if (cnt_q == LAST_CNT) begin
                  // Last strobe cycle: sample read data and raise ack.
                  state_q     <= ACK;
                  cnt_q       <= '0;
                  mem_read_q  <= 1'b0;
                  mem_write_q <= 1'b0;
                  if (win_q == REQ_DATA) begin
                     d_ack_q <= 1'b1;
                     if (!we_q) begin
                        d_rdata_q <= mem_rdata;
                     end
                  end else begin
                     i_ack_q   <= 1'b1;
                     i_rdata_q <= mem_rdata;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            ACK: begin
               state_q <= IDLE;
               i_ack_q <= 1'b0;
               i_err_q <= 1'b0;
               d_ack_q <= 1'b0;
               d_err_q <= 1'b0;
            end

            default: begin
               state_q     <= IDLE;
               mem_read_q  <= 1'b0;
               mem_write_q <= 1'b0;
            end
         endcase
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign i_ack     = i_ack_q;
   assign i_err     = i_err_q;
   assign d_ack     = d_ack_q;
   assign d_err     = d_err_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;

endmodule : mem_arbiter
